// File: rtl/poco_mem_arb.sv
// Purpose : round-robin arbiter sharing one single-port synchronous memory between
//           the POCO fetch port (I) and data port (D).
// Latency : request seen in IDLE cycle T -> m_en_o in T+1, ack in T+3.
//           At most one access every 4 cycles.
// Backpressure: a requester stalls, holding req/addr/data stable, until its
//           one-cycle ack. The losing port waits at most one other access.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   i_req_i/i_addr_i            fetch request and address
//   i_rdata_o/i_ack_o           fetched word (held until the next I read) and ack pulse
//   d_req_i/d_we_i/d_addr_i/d_wdata_i  data request, write flag, address, write data
//   d_rdata_o/d_ack_o           read word (held until the next D read) and ack pulse
//   m_en_o/m_we_o/m_addr_o/m_wdata_o   memory strobe, write enable, address, write data
//   m_rdata_i                   memory read data, valid one cycle after the read strobe
module poco_mem_arb #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 8,
  parameter bit D_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_i,
  input  logic [DATA_W-1:0] i_addr_i,
  output logic [DATA_W-1:0] i_rdata_o,
  output logic              i_ack_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [DATA_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_ack_o,
  output logic              m_en_o,
  output logic              m_we_o,
  output logic [ADDR_W-1:0] m_addr_o,
  output logic [DATA_W-1:0] m_wdata_o,
  input  logic [DATA_W-1:0] m_rdata_i
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

  state_t              state_q, state_d;
  logic                gnt_d_q, gnt_d_d;    // 1 = current access belongs to the D port
  logic                last_d_q, last_d_d;  // 1 = previous completed access was D
  logic                we_q, we_d;          // latched write flag of the current access
  logic                m_en_q, m_en_d;
  logic                m_we_q, m_we_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
  logic                i_ack_q, i_ack_d;
  logic                d_ack_q, d_ack_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                pick_d;

  always_comb begin
    state_d   = state_q;
    gnt_d_d   = gnt_d_q;
    last_d_d  = last_d_q;
    we_d      = we_q;
    m_en_d    = 1'b0;
    m_we_d    = 1'b0;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    pick_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_req_i || d_req_i) begin
          // D wins when it is alone, or on a tie when I was served last.
          pick_d   = d_req_i && (!i_req_i || !last_d_q);
          gnt_d_d  = pick_d;
          we_d     = pick_d && d_we_i;
          // Strobe and address are registered here so they appear during ISSUE.
          m_en_d   = 1'b1;
          m_we_d   = pick_d && d_we_i;
          m_addr_d = pick_d ? d_addr_i[ADDR_W-1:0] : i_addr_i[ADDR_W-1:0];
          if (pick_d) begin
            m_wdata_d = d_wdata_i;
          end
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Memory output is valid this cycle; writes leave the read registers alone.
        if (!we_q) begin
          if (gnt_d_q) begin
            d_rdata_d = m_rdata_i;
          end else begin
            i_rdata_d = m_rdata_i;
          end
        end
        // Ack is registered now so it is high during ACK.
        d_ack_d = gnt_d_q;
        i_ack_d = !gnt_d_q;
        state_d = S_ACK;
      end
      S_ACK: begin
        last_d_d = gnt_d_q;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      gnt_d_q   <= 1'b0;
      // Pretend the non-preferred port was served last so the preferred one wins the first tie.
      last_d_q  <= !D_FIRST;
      we_q      <= 1'b0;
      m_en_q    <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_d_q   <= gnt_d_d;
      last_d_q  <= last_d_d;
      we_q      <= we_d;
      m_en_q    <= m_en_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign m_en_o    = m_en_q;
  assign m_we_o    = m_we_q;
  assign m_addr_o  = m_addr_q;
  assign m_wdata_o = m_wdata_q;
  assign i_ack_o   = i_ack_q;
  assign d_ack_o   = d_ack_q;
  assign i_rdata_o = i_rdata_q;
  assign d_rdata_o = d_rdata_q;

endmodule

// File: tb/tb_poco_mem_arb.sv
// Purpose : self-checking bench for poco_mem_arb with a behavioural synchronous memory.
// Latency : expected acks are queued at request time with their due cycle (T+3, or later
//           under contention) and compared when the DUT acks.
// Backpressure: requests are held until their ack, then dropped.
module tb_poco_mem_arb;

  logic        clk;
  logic        rst_n;
  logic        i_req;
  logic [15:0] i_addr;
  logic [15:0] i_rdata;
  logic        i_ack;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        d_ack;
  logic        m_en;
  logic        m_we;
  logic [7:0]  m_addr;
  logic [15:0] m_wdata;
  logic [15:0] m_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    bit          pd;
    logic [15:0] exp;
    int          due;
    string       nm;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    bit          pd;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[11];

  logic [15:0] mem [256];

  poco_mem_arb #(.DATA_W(16), .ADDR_W(8), .D_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_i(i_req), .i_addr_i(i_addr), .i_rdata_o(i_rdata), .i_ack_o(i_ack),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_rdata_o(d_rdata), .d_ack_o(d_ack),
    .m_en_o(m_en), .m_we_o(m_we), .m_addr_o(m_addr), .m_wdata_o(m_wdata),
    .m_rdata_i(m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Single-port synchronous memory: read data appears one cycle after the strobe edge.
  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) mem[m_addr] = m_wdata;
      else      m_rdata <= mem[m_addr];
    end
  end

  // Ack monitor: pops the scoreboard on every ack and checks port, data and cycle.
  always @(negedge clk) begin
    exp_t e;
    bit   got_d;
    logic [15:0] rd;
    if (i_ack && d_ack) begin
      n_fail++;
      $display("FAIL double_ack cyc=%0d: i_ack=1 d_ack=1, required at most one", cyc);
    end
    if (m_we && !m_en) begin
      n_fail++;
      $display("FAIL we_without_en cyc=%0d: m_we=1 m_en=0", cyc);
    end
    if (i_ack || d_ack) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_ack cyc=%0d: i_ack=%0b d_ack=%0b, no ack expected", cyc, i_ack, d_ack);
      end else begin
        e = sb.pop_front();
        got_d = d_ack;
        rd = got_d ? d_rdata : i_rdata;
        if (got_d != e.pd || rd != e.exp || cyc != e.due)
          begin
            n_fail++;
            $display("FAIL %s: got port=%s data=%h cyc=%0d, required port=%s data=%h cyc=%0d",
                     e.nm, got_d ? "D" : "I", rd, cyc, e.pd ? "D" : "I", e.exp, e.due);
          end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input bit pd, input logic [15:0] exp, input int due, input string nm);
    exp_t e;
    e.pd = pd; e.exp = exp; e.due = due; e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic check_zero_outputs(input string nm);
    n_tests++;
    if ({m_en, m_we, i_ack, d_ack} != 4'b0 || m_addr != 8'h0 || m_wdata != 16'h0 ||
        i_rdata != 16'h0 || d_rdata != 16'h0) begin
      n_fail++;
      $display("FAIL %s: en=%0b we=%0b iack=%0b dack=%0b addr=%h wdata=%h irdata=%h drdata=%h, required all 0",
               nm, m_en, m_we, i_ack, d_ack, m_addr, m_wdata, i_rdata, d_rdata);
    end
  endtask

  // One isolated access: checks the memory strobe one cycle after the request
  // and queues the ack expected three cycles after it.
  task automatic do_access(input bit pd, input bit we, input logic [15:0] a,
                           input logic [15:0] wd, input logic [15:0] exp, input string nm);
    int  c0;
    bit  done;
    logic [7:0] a8;
    a8 = a[7:0];
    @(posedge clk); #1;
    c0 = cyc;
    if (pd) begin
      d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
    end else begin
      i_req = 1'b1; i_addr = a;
    end
    push_exp(pd, exp, c0 + 3, nm);
    @(posedge clk); #1;
    n_tests++;
    if (!(m_en === 1'b1 && m_we === we && m_addr === a8 && (!we || m_wdata === wd))) begin
      n_fail++;
      $display("FAIL %s_strobe: en=%0b we=%0b addr=%h wdata=%h, required en=1 we=%0b addr=%h wdata=%h",
               nm, m_en, m_we, m_addr, m_wdata, we, a8, wd);
    end
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(posedge clk); #1;
      if (pd ? d_ack : i_ack) begin
        if (pd) d_req = 1'b0; else i_req = 1'b0;
        done = 1'b1;
      end
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: no ack within 20 cycles, required ack at cycle %0d", nm, c0 + 3);
      i_req = 1'b0; d_req = 1'b0;
    end
  endtask

  initial begin
    int c0;
    int acks;
    bit done;

    for (int i = 0; i < 256; i++) mem[i] = 16'h5A00 | 16'(i);
    mem[5] = 16'h1234;
    mem[2] = 16'hBEEF;
    m_rdata = 16'h0;

    vecs[0]  = '{1'b0, 1'b0, 16'h0007, 16'h0000, 16'h5A07};
    vecs[1]  = '{1'b0, 1'b0, 16'h0005, 16'h0000, 16'h1234};
    vecs[2]  = '{1'b1, 1'b1, 16'h0009, 16'hA5A5, 16'hBEEF};  // write: d_rdata keeps last read
    vecs[3]  = '{1'b0, 1'b0, 16'h0009, 16'h0000, 16'hA5A5};
    vecs[4]  = '{1'b1, 1'b0, 16'h0009, 16'h0000, 16'hA5A5};
    vecs[5]  = '{1'b1, 1'b1, 16'h0103, 16'h3C3C, 16'hA5A5};  // wraps to address 3
    vecs[6]  = '{1'b0, 1'b0, 16'hFF03, 16'h0000, 16'h3C3C};
    vecs[7]  = '{1'b1, 1'b0, 16'h0006, 16'h0000, 16'h5A06};
    vecs[8]  = '{1'b1, 1'b1, 16'h00FF, 16'h0F0F, 16'h5A06};
    vecs[9]  = '{1'b1, 1'b0, 16'h01FF, 16'h0000, 16'h0F0F};
    vecs[10] = '{1'b0, 1'b0, 16'h0105, 16'h0000, 16'h1234};

    // Reset held with both ports requesting: nothing may move.
    rst_n = 1'b0;
    i_req = 1'b1; i_addr = 16'h0005;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0002; d_wdata = 16'h0;
    repeat (3) @(posedge clk);
    #1 check_zero_outputs("reset_hold_a");
    @(posedge clk); #1;
    check_zero_outputs("reset_hold_b");

    // Release: tie goes to D first, then strict alternation under continuous contention.
    rst_n = 1'b1;
    c0 = cyc;
    for (int k = 0; k < 8; k++)
      push_exp(k % 2 == 0, (k % 2 == 0) ? 16'hBEEF : 16'h1234, c0 + 3 + 4 * k,
               $sformatf("contend_%0d", k));
    @(posedge clk); #1;
    n_tests++;
    if (!(m_en === 1'b1 && m_we === 1'b0 && m_addr === 8'h02)) begin
      n_fail++;
      $display("FAIL first_strobe: en=%0b we=%0b addr=%h, required en=1 we=0 addr=02", m_en, m_we, m_addr);
    end
    acks = 0;
    done = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(posedge clk); #1;
      if (i_ack || d_ack) acks++;
      if (acks == 8) begin
        i_req = 1'b0; d_req = 1'b0;
        done = 1'b1;
      end
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL contend_timeout: %0d acks seen, required 8", acks);
      i_req = 1'b0; d_req = 1'b0;
    end
    repeat (3) @(posedge clk);

    // Isolated accesses from the vector table.
    for (int v = 0; v < 11; v++)
      do_access(vecs[v].pd, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].exp,
                $sformatf("vec_%0d", v));

    // Reset pulsed during WAIT of a D write to address 3: access abandoned, no ack.
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0003; d_wdata = 16'h7777;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    d_req = 1'b0; d_we = 1'b0;
    #1 check_zero_outputs("midreset_async");
    repeat (2) @(posedge clk);
    #1 check_zero_outputs("midreset_hold");
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1 check_zero_outputs("midreset_quiet");

    // Served normally afterwards; the write had already landed at the ISSUE edge.
    do_access(1'b1, 1'b0, 16'h0003, 16'h0000, 16'h7777, "post_reset_d");
    do_access(1'b0, 1'b0, 16'h0003, 16'h0000, 16'h7777, "post_reset_i");

    repeat (4) @(posedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL pending_acks: %0d expected acks never arrived, required 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
